// File: rtl/sym_freq_counter_if.sv
// rtl/sym_freq_counter_if.sv - symbol input stream bundle for the frequency counter
// Valid/ready beat carrying one symbol plus an end-of-stream flag.
interface sym_freq_counter_if #(
    parameter int SYM_W = 4
);
    logic             Din_valid;
    logic [SYM_W-1:0] Din;
    logic             Din_last;
    logic             Din_ready;

    modport master (
        output Din_valid,
        output Din,
        output Din_last,
        input  Din_ready
    );

    modport slave (
        input  Din_valid,
        input  Din,
        input  Din_last,
        output Din_ready
    );
endinterface

// File: rtl/sym_freq_counter.sv
// rtl/sym_freq_counter.sv - per-symbol frequency counter feeding the Huffman tree builder
// Counts a valid/ready symbol stream until last flag, out-of-range terminator or MAX_LEN symbols.
module sym_freq_counter #(
    parameter int NUM_SYM = 10,
    parameter int SYM_W   = 4,
    parameter int CNT_W   = 8,
    parameter int MAX_LEN = 256
) (
    input  logic                              Clk_in,
    input  logic                              Rst,
    input  logic                              Start,
    sym_freq_counter_if.slave                 din,
    output logic                              Busy,
    output logic                              Done,
    output logic [NUM_SYM*CNT_W-1:0]          Counts,
    output logic [$clog2(MAX_LEN+1)-1:0]      Total,
    output logic [$clog2(NUM_SYM+1)-1:0]      Distinct,
    output logic                              Sat
);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int DIST_W = $clog2(NUM_SYM + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q [NUM_SYM];
    logic [CNT_W-1:0]    cnt_d [NUM_SYM];
    logic [LEN_W-1:0]    total_q, total_d;
    logic [DIST_W-1:0]   dist_q, dist_d;
    logic                sat_q, sat_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                accept;
    logic                in_range;
    logic [LEN_W-1:0]    total_inc;

    assign din.Din_ready = (state_q == S_COUNT);
    assign accept        = din.Din_valid && din.Din_ready;
    // Widen by one bit so NUM_SYM == 2**SYM_W compares correctly.
    assign in_range      = ({1'b0, din.Din} < (SYM_W + 1)'(NUM_SYM));
    assign total_inc     = total_q + 1'b1;

    always_comb begin
        state_d = state_q;
        total_d = total_q;
        dist_d  = dist_q;
        sat_d   = sat_q;
        for (int i = 0; i < NUM_SYM; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_d = S_COUNT;
                    total_d = '0;
                    dist_d  = '0;
                    sat_d   = 1'b0;
                    for (int i = 0; i < NUM_SYM; i++) begin
                        cnt_d[i] = '0;
                    end
                end
            end
            S_COUNT: begin
                if (accept) begin
                    if (!in_range) begin
                        state_d = S_DONE;
                    end else begin
                        for (int i = 0; i < NUM_SYM; i++) begin
                            if (din.Din == SYM_W'(i)) begin
                                if (cnt_q[i] != CNT_MAX) begin
                                    cnt_d[i] = cnt_q[i] + 1'b1;
                                end
                                if (cnt_q[i] == '0) begin
                                    dist_d = dist_q + 1'b1;
                                end
                                if (cnt_d[i] == CNT_MAX) begin
                                    sat_d = 1'b1;
                                end
                            end
                        end
                        total_d = total_inc;
                        if (din.Din_last || (total_inc == LEN_W'(MAX_LEN))) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_COUNT);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clk_in or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            total_q <= '0;
            dist_q  <= '0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_SYM; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            dist_q  <= dist_d;
            sat_q   <= sat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int i = 0; i < NUM_SYM; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_SYM; g++) begin : g_counts
            assign Counts[g*CNT_W +: CNT_W] = cnt_q[g];
        end
    endgenerate

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Total    = total_q;
    assign Distinct = dist_q;
    assign Sat      = sat_q;
endmodule

// File: tb/tb_sym_freq_counter.sv
// tb/tb_sym_freq_counter.sv - randomized self-checking bench for sym_freq_counter
// Reference keeps the accepted symbols in a queue and derives all results from it.
module tb_sym_freq_counter;
    localparam int NS   = 10;
    localparam int SW   = 4;
    localparam int CW   = 8;
    localparam int ML   = 256;
    localparam int LW   = $clog2(ML + 1);
    localparam int DW   = $clog2(NS + 1);
    localparam int DW16 = $clog2(17);
    localparam int CMAX = 255;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic start16;
    always #5 clk = ~clk;

    sym_freq_counter_if #(.SYM_W(SW)) sif ();
    sym_freq_counter_if #(.SYM_W(SW)) sif16 ();

    logic              busy, done, sat;
    logic [NS*CW-1:0]  counts;
    logic [LW-1:0]     total;
    logic [DW-1:0]     distinct;

    logic              busy16, done16, sat16;
    logic [16*CW-1:0]  counts16;
    logic [LW-1:0]     total16;
    logic [DW16-1:0]   distinct16;

    sym_freq_counter #(.NUM_SYM(NS), .SYM_W(SW), .CNT_W(CW), .MAX_LEN(ML)) dut (
        .Clk_in(clk), .Rst(rst), .Start(start), .din(sif),
        .Busy(busy), .Done(done), .Counts(counts), .Total(total),
        .Distinct(distinct), .Sat(sat)
    );

    sym_freq_counter #(.NUM_SYM(16), .SYM_W(SW), .CNT_W(CW), .MAX_LEN(ML)) dut16 (
        .Clk_in(clk), .Rst(rst), .Start(start16), .din(sif16),
        .Busy(busy16), .Done(done16), .Counts(counts16), .Total(total16),
        .Distinct(distinct16), .Sat(sat16)
    );

    int errors = 0;
    int checks = 0;
    int sq[$];
    bit ended;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_result(input string tag);
        int c[NS];
        int d;
        bit s;
        foreach (c[i]) c[i] = 0;
        foreach (sq[k]) c[sq[k]]++;
        d = 0;
        s = 1'b0;
        foreach (c[i]) begin
            if (c[i] > 0) d++;
            if (c[i] >= CMAX) s = 1'b1;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, sif.Din_ready, 0);
        for (int i = 0; i < NS; i++) begin
            chk($sformatf("%s_cnt%0d", tag, i), counts[i*CW +: CW], (c[i] > CMAX) ? CMAX : c[i]);
        end
        chk({tag, "_total"}, total, sq.size());
        chk({tag, "_distinct"}, distinct, d);
        chk({tag, "_sat"}, sat, s);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_sat"}, sat, 0);
        chk({tag, "_counts"}, (counts == '0), 1);
        chk({tag, "_total"}, total, 0);
        chk({tag, "_distinct"}, distinct, 0);
        chk({tag, "_ready"}, sif.Din_ready, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sq.delete();
        ended = 1'b0;
    endtask

    task automatic push(input int sym, input bit last);
        bit acc;
        sif.Din       = SW'(sym);
        sif.Din_last  = last;
        sif.Din_valid = 1'b1;
        @(negedge clk);
        acc = sif.Din_ready;
        @(posedge clk); #1;
        sif.Din_valid = 1'b0;
        sif.Din_last  = 1'b0;
        chk("ready", acc, !ended);
        if (acc && !ended) begin
            if (sym >= NS) begin
                ended = 1'b1;
            end else begin
                sq.push_back(sym);
                if (last || sq.size() == ML) ended = 1'b1;
            end
        end
    endtask

    task automatic gap(input int n);
        for (int k = 0; k < n; k++) begin
            start = ($urandom_range(0, 2) == 0);
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start16 = 1'b0;
        sif.Din_valid = 1'b0; sif.Din = '0; sif.Din_last = 1'b0;
        sif16.Din_valid = 1'b0; sif16.Din = '0; sif16.Din_last = 1'b0;
        ended = 1'b0;
        #12;
        check_zero("reset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        do_start();
        chk("t1_busy", busy, 1);
        push(0, 0); push(1, 0); push(1, 0); push(9, 0); push(3, 1);
        expect_result("t1");

        do_start();
        push(2, 0); push(2, 0); push(10, 0); push(7, 0);
        expect_result("t2");

        do_start();
        for (int k = 0; k < ML - 1; k++) push(5, 0);
        chk("t3_busy_before_last", busy, 1);
        chk("t3_done_before_last", done, 0);
        push(5, 0);
        expect_result("t3");

        do_start();
        chk("t6_busy", busy, 1);
        chk("t6_done", done, 0);
        chk("t6_sat", sat, 0);
        chk("t6_total", total, 0);
        chk("t6_distinct", distinct, 0);
        chk("t6_counts", (counts == '0), 1);

        for (int s = 0; s < 8; s++) begin
            int len;
            if (s > 0) do_start();
            len = $urandom_range(1, 40);
            for (int j = 0; j < len && !ended; j++) begin
                int sym;
                gap($urandom_range(0, 2));
                sym = ($urandom_range(0, 12) == 0) ? $urandom_range(NS, 15) : $urandom_range(0, NS - 1);
                push(sym, j == len - 1);
            end
            expect_result($sformatf("t4_s%0d", s));
        end

        do_start();
        for (int k = 0; k < ML; k++) push($urandom_range(0, NS - 1), k == ML - 1);
        push(1, 1);
        expect_result("t4_maxlast");

        do_start();
        push(1, 0); push(2, 0); push(3, 0);
        rst = 1'b1;
        #1;
        check_zero("t5_rst");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("t5_idle_ready", sif.Din_ready, 0);
        do_start();
        push(4, 1);
        expect_result("t5");

        start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        chk("t6b_busy", busy16, 1);
        sif16.Din = 4'd15; sif16.Din_last = 1'b1; sif16.Din_valid = 1'b1;
        @(posedge clk); #1;
        sif16.Din_valid = 1'b0; sif16.Din_last = 1'b0;
        chk("t6b_cnt15", counts16[15*CW +: CW], 1);
        chk("t6b_total", total16, 1);
        chk("t6b_distinct", distinct16, 1);
        chk("t6b_done", done16, 1);
        chk("t6b_sat", sat16, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
